// File: rtl/ysyx_rf_pkg.sv
// Shared defaults and helpers for the ysyx register file with busy scoreboard.
// NR_REGS must not exceed MAX_REGS, the operand width popcount accepts.
package ysyx_rf_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NR_REGS_DEF = 32;
    localparam int unsigned NUM_RD_DEF  = 2;
    localparam int unsigned MAX_REGS    = 256;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ysyx_rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
// busy_cnt is the live popcount of the busy state, not a delayed copy.
module ysyx_rf_scoreboard
    import ysyx_rf_pkg::*;
#(
    parameter int unsigned NR_REGS = NR_REGS_DEF,
    parameter int unsigned AW      = $clog2(NR_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      waddr,
    input  logic               issue_en,
    input  logic [AW-1:0]      issue_rd,
    input  logic               flush,
    output logic [NR_REGS-1:0] busy,
    output logic [AW:0]        busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NR_REGS-1:0] busy_q;
    logic [NR_REGS-1:0] busy_d;

    // Priority low to high: write-clear, issue-set, flush; x0 is never busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && (waddr != '0)) begin
            busy_d[waddr] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = CW'(popcount(MAX_REGS'(busy_q)));

endmodule

// File: rtl/ysyx_regfile_sb.sv
// NPC integer register file: NUM_RD combinational reads, one write, busy scoreboard.
// Define YSYX_REGFILE_BYPASS_EN to forward same-cycle write data/clear onto reads.
module ysyx_regfile_sb
    import ysyx_rf_pkg::*;
#(
    parameter int unsigned  XLEN    = XLEN_DEF,
    parameter int unsigned  NR_REGS = NR_REGS_DEF,
    parameter int unsigned  NUM_RD  = NUM_RD_DEF,
    localparam int unsigned AW      = $clog2(NR_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    logic [XLEN-1:0]    regs_q [NR_REGS];
    logic [XLEN-1:0]    regs_d [NR_REGS];
    logic [NR_REGS-1:0] busy_vec;

    // Entry 0 is never written, so it holds its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    ysyx_rf_scoreboard #(
        .NR_REGS (NR_REGS),
        .AW      (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .waddr    (waddr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy     (busy_vec),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdata[k*XLEN +: XLEN] = regs_q[raddr[k*AW +: AW]];
            rbusy[k]              = busy_vec[raddr[k*AW +: AW]];
`ifdef YSYX_REGFILE_BYPASS_EN
            // A same-cycle issue to this index only lands at the edge, so busy reads 0 now.
            if (wr_en && (waddr != '0) && (waddr == raddr[k*AW +: AW])) begin
                rdata[k*XLEN +: XLEN] = wdata;
                rbusy[k]              = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
// Directed table-driven bench for ysyx_regfile_sb plus bypass and async-reset sequences.
module tb_ysyx_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [5:0]  busy_cnt;

    int unsigned n_total;
    int unsigned n_pass;

    ysyx_regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        is;
        logic [4:0]  ir;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        waddr    = '0;
        wdata    = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        flush    = 1'b0;
    endtask

    // Drive controls for one edge, then release them so reads show stored state only.
    task automatic step(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic is, input logic [4:0] ir, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        wr_en = wr; waddr = wa; wdata = wd;
        issue_en = is; issue_rd = ir; flush = fl;
        raddr = {r1, r0};
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle();
        raddr = '0;
        rst_n = 1'b0;

        //            wr   wa     wd            is   ir     fl   r0     r1     e0            e1            eb     ec
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        2'b11, 6'd1};
        vecs[3]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'h55,       32'hDEADBEEF, 2'b00, 6'd0};
        vecs[4]  = '{1'b1, 5'd9,  32'h000000AA, 1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'hAA,       32'hAA,       2'b11, 6'd1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd9,  32'h0,        32'hAA,       2'b11, 6'd2};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd3,  32'h0,        32'h0,        2'b01, 6'd3};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd1,  32'h0,        32'h0,        2'b11, 6'd4};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd0,  32'hAA,       32'h0,        2'b01, 6'd4};
        vecs[9]  = '{1'b1, 5'd1,  32'h00000011, 1'b1, 5'd4,  1'b1, 5'd4,  5'd1,  32'h0,        32'h11,       2'b00, 6'd0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 1'b0, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        2'b10, 6'd1};
        vecs[12] = '{1'b1, 5'd30, 32'h00000003, 1'b0, 5'd0,  1'b0, 5'd30, 5'd31, 32'h3,        32'hFFFFFFFF, 2'b00, 6'd0};

        #12;
        rst_n = 1'b1;
        #1;

        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("reset_rdata_x%0d", i), rdata, 64'd0);
            chk($sformatf("reset_rbusy_x%0d", i), 64'(rbusy), 64'd0);
        end

        for (int v = 0; v < NV; v++) begin
            step(vecs[v].wr, vecs[v].wa, vecs[v].wd, vecs[v].is, vecs[v].ir, vecs[v].fl,
                 vecs[v].r0, vecs[v].r1);
            chk($sformatf("vec%0d_rdata0", v), 64'(rdata[31:0]), 64'(vecs[v].e0));
            chk($sformatf("vec%0d_rdata1", v), 64'(rdata[63:32]), 64'(vecs[v].e1));
            chk($sformatf("vec%0d_rbusy", v), 64'(rbusy), 64'(vecs[v].eb));
            chk($sformatf("vec%0d_busy_cnt", v), 64'(busy_cnt), 64'(vecs[v].ec));
        end

        // Same-cycle write visibility: x4 holds 0x1111 and is busy while 0xCAFE is being written.
        step(1'b1, 5'd4, 32'h1111, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
        chk("x4_pre_rdata", 64'(rdata[31:0]), 64'h1111);
        chk("x4_pre_rbusy", 64'(rbusy), 64'b01);
        @(negedge clk);
        wr_en = 1'b1; waddr = 5'd4; wdata = 32'hCAFE;
        raddr = {5'd0, 5'd4};
        #1;
`ifdef YSYX_REGFILE_BYPASS_EN
        chk("bypass_rdata0", 64'(rdata[31:0]), 64'hCAFE);
        chk("bypass_rbusy0", 64'(rbusy), 64'b00);
`else
        chk("nobypass_rdata0", 64'(rdata[31:0]), 64'h1111);
        chk("nobypass_rbusy0", 64'(rbusy), 64'b01);
`endif
        chk("same_cycle_busy_cnt", 64'(busy_cnt), 64'd1);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("x4_post_rdata", 64'(rdata[31:0]), 64'hCAFE);
        chk("x4_post_rbusy", 64'(rbusy), 64'b00);
        chk("x4_post_busy_cnt", 64'(busy_cnt), 64'd0);

        // Asynchronous reset between edges wipes data and busy state immediately.
        step(1'b1, 5'd10, 32'h77, 1'b1, 5'd11, 1'b0, 5'd10, 5'd11);
        chk("x10_rdata", 64'(rdata[31:0]), 64'h77);
        chk("x11_rbusy", 64'(rbusy), 64'b10);
        chk("pre_rst_busy_cnt", 64'(busy_cnt), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", rdata, 64'd0);
        chk("async_rst_rbusy", 64'(rbusy), 64'd0);
        chk("async_rst_busy_cnt", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
        chk("post_rst_rdata", rdata, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
